otter_lsu_align: RTL and testbench



---
 rtl/otter_mem_pkg.sv | 25 ++
 rtl/otter_load_align.sv | 26 ++
 rtl/otter_lsu_align.sv | 192 +++++++++++++++++++
 tb/tb_otter_lsu_align.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_mem_pkg.sv
// Shared types and helpers for the Otter data-port load/store aligner.
// Crossing means the access would touch bytes in two different 32-bit words.
package otter_mem_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE,
    RD_HI,
    WR_BYTES,
    RSP
  } lsu_state_t;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'h1100_0000;

  function automatic logic is_crossing(input logic [31:0] addr, input logic [1:0] size);
    return ((size == HALF) && (addr[1:0] == 2'd3)) ||
           ((size == WORD) && (addr[1:0] != 2'd0));
  endfunction

endpackage

// File: rtl/otter_load_align.sv
// Combinational load extractor: picks the addressed bytes out of {hi, lo},
// then zero- or sign-extends them to 32 bits.
module otter_load_align
  import otter_mem_pkg::*;
(
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] result
);

  logic [31:0] merged;

  always_comb begin
    merged = 32'({hi, lo} >> {offset, 3'b000});
    result = merged;
    case (mem_size_t'(size))
      BYTE:    result = uns ? {24'd0, merged[7:0]}  : {{24{merged[7]}}, merged[7:0]};
      HALF:    result = uns ? {16'd0, merged[15:0]} : {{16{merged[15]}}, merged[15:0]};
      default: result = merged;
    endcase
  end

endmodule

// File: rtl/otter_lsu_align.sv
// Load/store aligner between the Otter MEM stage and memory port 2: issues only
// word-contained accesses, splitting or trapping accesses that cross a word.
module otter_lsu_align
  import otter_mem_pkg::*;
#(
  parameter logic [31:0] IO_BASE      = IO_BASE_DEFAULT,
  parameter bit          ENABLE_SPLIT = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_VALID,
  input  logic        REQ_WE,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  input  logic [1:0]  REQ_SIZE,
  input  logic        REQ_SIGN,
  output logic        STALL,
  output logic        RSP_VALID,
  output logic [31:0] RSP_RDATA,
  output logic        MISALIGN_TRAP,
  output logic [31:0] MEM_ADDR2,
  output logic [31:0] MEM_DIN2,
  output logic        MEM_WRITE2,
  output logic        MEM_READ2,
  output logic [1:0]  MEM_SIZE,
  output logic        MEM_SIGN,
  input  logic [31:0] MEM_DOUT2
);

  lsu_state_t  state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, lo_q, lo_d;
  logic [1:0]  size_q, size_d, idx_q, idx_d;
  logic        sign_q, sign_d, io_q, io_d, split_q, split_d;

  logic        req_live, req_io, req_cross;
  logic [1:0]  last_idx;
  logic [31:0] lo_word, aligned;

  assign req_live  = REQ_VALID && (REQ_SIZE != 2'd3);
  assign req_io    = (REQ_ADDR >= IO_BASE);
  assign req_cross = !req_io && is_crossing(REQ_ADDR, REQ_SIZE);
  assign last_idx  = (size_q == WORD) ? 2'd3 : 2'd1;

  // Aligned loads see the same word in both halves; split loads use the held lo word.
  assign lo_word = split_q ? lo_q : MEM_DOUT2;

  otter_load_align u_load_align (
    .hi     (MEM_DOUT2),
    .lo     (lo_word),
    .offset (addr_q[1:0]),
    .size   (size_q),
    .uns    (sign_q),
    .result (aligned)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
      size_q  <= '0;
      idx_q   <= '0;
      sign_q  <= 1'b0;
      io_q    <= 1'b0;
      split_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      lo_q    <= lo_d;
      size_q  <= size_d;
      idx_q   <= idx_d;
      sign_q  <= sign_d;
      io_q    <= io_d;
      split_q <= split_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    lo_d    = lo_q;
    size_d  = size_q;
    idx_d   = idx_q;
    sign_d  = sign_q;
    io_d    = io_q;
    split_d = split_q;
    case (state_q)
      IDLE, RSP: begin
        state_d = IDLE;
        if (req_live) begin
          addr_d  = REQ_ADDR;
          wdata_d = REQ_WDATA;
          size_d  = REQ_SIZE;
          sign_d  = REQ_SIGN;
          io_d    = req_io;
          split_d = 1'b0;
          if (req_cross) begin
            if (ENABLE_SPLIT) begin
              if (REQ_WE) begin
                state_d = WR_BYTES;
                idx_d   = 2'd1;
              end else begin
                state_d = RD_HI;
              end
            end
          end else if (!REQ_WE) begin
            state_d = RSP;
          end
        end
      end
      RD_HI: begin
        lo_d    = MEM_DOUT2;
        split_d = 1'b1;
        state_d = RSP;
      end
      WR_BYTES: begin
        if (idx_q == last_idx) state_d = IDLE;
        else                   idx_d   = idx_q + 2'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    STALL         = 1'b0;
    RSP_VALID     = 1'b0;
    RSP_RDATA     = '0;
    MISALIGN_TRAP = 1'b0;
    MEM_ADDR2     = '0;
    MEM_DIN2      = '0;
    MEM_WRITE2    = 1'b0;
    MEM_READ2     = 1'b0;
    MEM_SIZE      = WORD;
    MEM_SIGN      = 1'b0;
    if (!RST) begin
      if (state_q == RSP) begin
        RSP_VALID = 1'b1;
        RSP_RDATA = io_q ? MEM_DOUT2 : aligned;
      end
      case (state_q)
        IDLE, RSP: begin
          if (req_live) begin
            if (req_cross && !ENABLE_SPLIT) begin
              MISALIGN_TRAP = 1'b1;
            end else if (req_cross && REQ_WE) begin
              // Byte 0 goes out straight from the request; the rest come from WR_BYTES.
              MEM_WRITE2 = 1'b1;
              MEM_ADDR2  = REQ_ADDR;
              MEM_DIN2   = {24'd0, REQ_WDATA[7:0]};
              MEM_SIZE   = BYTE;
              STALL      = 1'b1;
            end else if (req_cross) begin
              MEM_READ2 = 1'b1;
              MEM_ADDR2 = {REQ_ADDR[31:2], 2'b00};
              STALL     = 1'b1;
            end else if (REQ_WE) begin
              MEM_WRITE2 = 1'b1;
              MEM_ADDR2  = REQ_ADDR;
              MEM_DIN2   = REQ_WDATA;
              MEM_SIZE   = REQ_SIZE;
              MEM_SIGN   = REQ_SIGN;
            end else if (req_io) begin
              MEM_READ2 = 1'b1;
              MEM_ADDR2 = REQ_ADDR;
              MEM_SIZE  = REQ_SIZE;
              MEM_SIGN  = REQ_SIGN;
            end else begin
              MEM_READ2 = 1'b1;
              MEM_ADDR2 = {REQ_ADDR[31:2], 2'b00};
            end
          end
        end
        RD_HI: begin
          MEM_READ2 = 1'b1;
          MEM_ADDR2 = {addr_q[31:2], 2'b00} + 32'd4;
        end
        WR_BYTES: begin
          MEM_WRITE2 = 1'b1;
          MEM_ADDR2  = addr_q + 32'(idx_q);
          MEM_DIN2   = {24'd0, 8'(wdata_q >> {idx_q, 3'b000})};
          MEM_SIZE   = BYTE;
          STALL      = (idx_q != last_idx);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_otter_lsu_align.sv
// Directed bench for otter_lsu_align: expected memory strobes and load results
// are queued at issue time and checked by independent negedge monitors.
module tb_otter_lsu_align;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, req_we, req_sign;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        stall, rsp_valid, trap, mem_write, mem_read, mem_sign;
  logic [31:0] rsp_rdata, mem_addr, mem_din, mem_dout;
  logic [1:0]  mem_size;

  logic        ns_req_valid, ns_req_we, ns_req_sign;
  logic [31:0] ns_req_addr, ns_req_wdata;
  logic [1:0]  ns_req_size;
  logic        ns_stall, ns_rsp_valid, ns_trap, ns_mem_write, ns_mem_read, ns_mem_sign;
  logic [31:0] ns_rsp_rdata, ns_mem_addr, ns_mem_din, ns_mem_dout;
  logic [1:0]  ns_mem_size;

  otter_lsu_align dut (
    .CLK(clk), .RST(rst), .REQ_VALID(req_valid), .REQ_WE(req_we), .REQ_ADDR(req_addr),
    .REQ_WDATA(req_wdata), .REQ_SIZE(req_size), .REQ_SIGN(req_sign), .STALL(stall),
    .RSP_VALID(rsp_valid), .RSP_RDATA(rsp_rdata), .MISALIGN_TRAP(trap),
    .MEM_ADDR2(mem_addr), .MEM_DIN2(mem_din), .MEM_WRITE2(mem_write), .MEM_READ2(mem_read),
    .MEM_SIZE(mem_size), .MEM_SIGN(mem_sign), .MEM_DOUT2(mem_dout)
  );

  otter_lsu_align #(.ENABLE_SPLIT(1'b0)) dut_ns (
    .CLK(clk), .RST(rst), .REQ_VALID(ns_req_valid), .REQ_WE(ns_req_we), .REQ_ADDR(ns_req_addr),
    .REQ_WDATA(ns_req_wdata), .REQ_SIZE(ns_req_size), .REQ_SIGN(ns_req_sign), .STALL(ns_stall),
    .RSP_VALID(ns_rsp_valid), .RSP_RDATA(ns_rsp_rdata), .MISALIGN_TRAP(ns_trap),
    .MEM_ADDR2(ns_mem_addr), .MEM_DIN2(ns_mem_din), .MEM_WRITE2(ns_mem_write), .MEM_READ2(ns_mem_read),
    .MEM_SIZE(ns_mem_size), .MEM_SIGN(ns_mem_sign), .MEM_DOUT2(ns_mem_dout)
  );

  localparam logic [31:0] IO_PAT = 32'hA5C3_0F1E;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic note_fail(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    if (act !== exp) note_fail(name, act, exp);
    else begin
      n_checks++;
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Byte-addressed memory model; only the low 512 bytes are backed.
  logic [7:0] mem [0:511];
  logic       preload_en;

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    logic [8:0] b;
    b = {a[8:2], 2'b00};
    return {mem[b + 9'd3], mem[b + 9'd2], mem[b + 9'd1], mem[b]};
  endfunction

  always @(posedge clk) begin
    if (preload_en) begin
      for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
      mem[9'h100] <= 8'h11; mem[9'h101] <= 8'h22; mem[9'h102] <= 8'h33; mem[9'h103] <= 8'h44;
      mem[9'h104] <= 8'h55; mem[9'h105] <= 8'h66; mem[9'h106] <= 8'h77; mem[9'h107] <= 8'h88;
      mem[9'h108] <= 8'h99; mem[9'h109] <= 8'hAA; mem[9'h10A] <= 8'hBB; mem[9'h10B] <= 8'hCC;
    end else begin
      if (mem_read) mem_dout <= (mem_addr >= 32'h1100_0000) ? IO_PAT : rd_word(mem_addr);
      if (mem_write && mem_addr < 32'h1100_0000) begin
        for (int k = 0; k < 4; k++) begin
          if ((mem_size == 2'd2) || (mem_size == 2'd1 && k < 2) || (k == 0))
            mem[9'(mem_addr + 32'(k))] <= mem_din[8*k +: 8];
        end
      end
    end
  end

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] din;
    logic [1:0]  size;
    logic        sign;
    logic        stall;
  } strobe_t;

  strobe_t     exp_strobe[$];
  logic [31:0] exp_rsp[$];
  strobe_t     mon_e, mon_a;
  logic [31:0] mon_mask, mon_r;
  int          ns_trap_cnt  = 0;
  int          ns_write_cnt = 0;

  task automatic exp_rd(input logic [31:0] a, input logic [1:0] sz, input logic sg, input logic st);
    strobe_t s;
    s.we = 1'b0; s.addr = a; s.din = '0; s.size = sz; s.sign = sg; s.stall = st;
    exp_strobe.push_back(s);
  endtask

  task automatic exp_wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz, input logic st);
    strobe_t s;
    s.we = 1'b1; s.addr = a; s.din = d; s.size = sz; s.sign = 1'b0; s.stall = st;
    exp_strobe.push_back(s);
  endtask

  // Strobe and response monitor for the splitting instance.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_read || mem_write) begin
        mon_mask = !mem_write ? 32'h0 : (mem_size == 2'd0) ? 32'hFF :
                   (mem_size == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
        mon_a.we = mem_write; mon_a.addr = mem_addr; mon_a.din = mem_din & mon_mask;
        mon_a.size = mem_size; mon_a.sign = mem_sign; mon_a.stall = stall;
        if (exp_strobe.size() == 0) note_fail("unexpected strobe", mon_a, 0);
        else begin
          mon_e = exp_strobe.pop_front();
          chk("strobe we/addr/din/size/sign/stall", mon_a, mon_e);
        end
      end
      if (rsp_valid) begin
        if (exp_rsp.size() == 0) note_fail("unexpected rsp", rsp_rdata, 0);
        else begin
          mon_r = exp_rsp.pop_front();
          chk("rsp_rdata", rsp_rdata, mon_r);
        end
      end
      if (trap) note_fail("split instance trap", trap, 0);
      if (ns_trap) ns_trap_cnt++;
      if (ns_mem_write) ns_write_cnt++;
    end
  end

  // Caller is just after a posedge; returns just after the accepting posedge.
  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, input logic sg);
    int n;
    n = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_size = sz; req_sign = sg;
    @(negedge clk);
    while (stall && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (stall) note_fail("accept timeout", n, 0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    $display("req we=%0b addr=%h size=%0d sign=%0b accepted after %0d stall cycles", we, a, sz, sg, n);
  endtask

  initial begin
    rst = 1'b1; preload_en = 1'b1; mem_dout = '0; ns_mem_dout = 32'h0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h101; req_wdata = '0; req_size = 2'd2; req_sign = 1'b0;
    ns_req_valid = 1'b0; ns_req_we = 1'b0; ns_req_addr = '0; ns_req_wdata = '0; ns_req_size = 2'd0; ns_req_sign = 1'b0;
    repeat (2) @(posedge clk);
    #1 preload_en = 1'b0;
    @(negedge clk);
    chk("reset stall", stall, 0);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset rsp_rdata", rsp_rdata, 0);
    chk("reset mem_read", mem_read, 0);
    chk("reset mem_write", mem_write, 0);
    @(posedge clk);
    #1 rst = 1'b0; req_valid = 1'b0;

    // Loads issued back to back
    exp_rd(32'h100, 2'd2, 1'b0, 1'b0); exp_rsp.push_back(32'h0000_0033);
    issue(1'b0, 32'h102, '0, 2'd0, 1'b1);
    exp_rd(32'h100, 2'd2, 1'b0, 1'b1); exp_rd(32'h104, 2'd2, 1'b0, 1'b0); exp_rsp.push_back(32'h5544_3322);
    issue(1'b0, 32'h101, '0, 2'd2, 1'b0);
    exp_rd(32'h104, 2'd2, 1'b0, 1'b1); exp_rd(32'h108, 2'd2, 1'b0, 1'b0); exp_rsp.push_back(32'hFFFF_9988);
    issue(1'b0, 32'h107, '0, 2'd1, 1'b0);
    exp_rd(32'h104, 2'd2, 1'b0, 1'b1); exp_rd(32'h108, 2'd2, 1'b0, 1'b0); exp_rsp.push_back(32'h0000_9988);
    issue(1'b0, 32'h107, '0, 2'd1, 1'b1);
    exp_rd(32'h104, 2'd2, 1'b0, 1'b0); exp_rsp.push_back(32'h8877_6655);
    issue(1'b0, 32'h104, '0, 2'd2, 1'b0);
    exp_rd(32'h108, 2'd2, 1'b0, 1'b0); exp_rsp.push_back(32'hCCBB_AA99);
    issue(1'b0, 32'h108, '0, 2'd2, 1'b0);
    exp_rd(32'h104, 2'd2, 1'b0, 1'b0); exp_rsp.push_back(32'hFFFF_FF88);
    issue(1'b0, 32'h107, '0, 2'd0, 1'b0);
    // MMIO load passes through unsplit and unmodified
    exp_rd(32'h1100_0002, 2'd2, 1'b0, 1'b0); exp_rsp.push_back(IO_PAT);
    issue(1'b0, 32'h1100_0002, '0, 2'd2, 1'b0);
    // Illegal size: nothing on the memory port, no response
    issue(1'b0, 32'h100, '0, 2'd3, 1'b0);

    // Reset while the split load sits in RD_HI
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h101; req_size = 2'd2; req_sign = 1'b0;
    exp_rd(32'h100, 2'd2, 1'b0, 1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst in RD_HI stall", stall, 0);
    chk("rst in RD_HI rsp_valid", rsp_valid, 0);
    chk("rst in RD_HI mem_read", mem_read, 0);
    @(posedge clk);
    #1 rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("after rst stall", stall, 0);
    chk("after rst rsp_valid", rsp_valid, 0);
    chk("after rst mem_read", mem_read, 0);
    @(posedge clk);
    #1;

    // Crossing word store becomes four byte stores
    exp_wr(32'h0FE, 32'hEF, 2'd0, 1'b1); exp_wr(32'h0FF, 32'hBE, 2'd0, 1'b1);
    exp_wr(32'h100, 32'hAD, 2'd0, 1'b1); exp_wr(32'h101, 32'hDE, 2'd0, 1'b0);
    issue(1'b1, 32'h0FE, 32'hDEAD_BEEF, 2'd2, 1'b0);
    exp_rd(32'h100, 2'd2, 1'b0, 1'b0); exp_rsp.push_back(32'h4433_DEAD);
    issue(1'b0, 32'h100, '0, 2'd2, 1'b0);
    exp_rd(32'h100, 2'd2, 1'b0, 1'b0); exp_rsp.push_back(32'hFFFF_FFDE);
    issue(1'b0, 32'h101, '0, 2'd0, 1'b0);
    // Aligned half store, then reads over it
    exp_wr(32'h108, 32'h1234, 2'd1, 1'b0);
    issue(1'b1, 32'h108, 32'h0000_1234, 2'd1, 1'b0);
    exp_rd(32'h108, 2'd2, 1'b0, 1'b0); exp_rsp.push_back(32'hCCBB_1234);
    issue(1'b0, 32'h108, '0, 2'd2, 1'b0);
    exp_rd(32'h108, 2'd2, 1'b0, 1'b0); exp_rsp.push_back(32'hFFFF_FFCC);
    issue(1'b0, 32'h10B, '0, 2'd0, 1'b0);

    // Split disabled: crossing store traps, crossing load traps, aligned load still works
    ns_req_valid = 1'b1; ns_req_we = 1'b1; ns_req_addr = 32'h101; ns_req_wdata = 32'h1234_5678; ns_req_size = 2'd2;
    @(negedge clk);
    chk("ns sw trap", ns_trap, 1);
    chk("ns sw stall", ns_stall, 0);
    chk("ns sw mem_write", ns_mem_write, 0);
    @(posedge clk);
    #1 ns_req_we = 1'b0;
    @(negedge clk);
    chk("ns lw trap", ns_trap, 1);
    chk("ns lw mem_read", ns_mem_read, 0);
    @(posedge clk);
    #1 ns_req_addr = 32'h100;
    @(negedge clk);
    chk("ns aligned lw trap", ns_trap, 0);
    chk("ns aligned lw mem_read", ns_mem_read, 1);
    @(posedge clk);
    #1 ns_req_valid = 1'b0;
    @(negedge clk);
    chk("ns aligned lw rsp_valid", ns_rsp_valid, 1);
    chk("ns idle trap", ns_trap, 0);

    for (int i = 0; i < 20 && (exp_strobe.size() != 0 || exp_rsp.size() != 0); i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("pending strobes", exp_strobe.size(), 0);
    chk("pending responses", exp_rsp.size(), 0);
    chk("ns trap pulses", ns_trap_cnt, 2);
    chk("ns write strobes", ns_write_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
